// File: rtl/pipe_adder.sv
// pipe_adder: WIDTH-bit adder split into STAGES ripple-carry segments, valid/ready on both sides.
// Optional feature macro PIPE_ADDER_SUB_EN adds a sub port selecting a + ~b + 1.
module pipe_adder #(
   parameter int WIDTH  = 8,
   parameter int STAGES = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
`ifdef PIPE_ADDER_SUB_EN
   input  logic             sub,
`endif
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] s,
   output logic             cout,
   output logic             ovf
);
   localparam int SEG = WIDTH / STAGES;

   // Full-adder cell: returns {carry, sum}.
   function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
      return {(x & y) | (ci & (x ^ y)), x ^ y ^ ci};
   endfunction

   logic             adv;
   logic [WIDTH-1:0] b_eff;
   logic             cin_eff;

`ifdef PIPE_ADDER_SUB_EN
   assign b_eff   = sub ? ~b : b;
   assign cin_eff = sub ? 1'b1 : cin;
`else
   assign b_eff   = b;
   assign cin_eff = cin;
`endif

   generate
      for (genvar gi = 0; gi < STAGES; gi++) begin : stg
         localparam int W_IN = WIDTH - gi * SEG;

         logic [W_IN-1:0]         op_a;
         logic [W_IN-1:0]         op_b;
         logic                    c_in;
         logic                    v_in;
         logic                    carry_next;
         logic [SEG-1:0]          seg_sum;
         logic [(gi+1)*SEG-1:0]   sum_next;
         logic [(gi+1)*SEG-1:0]   sum_reg;
         logic                    valid_reg;
         logic                    carry_reg;

         if (gi == 0) begin : src
            assign op_a     = a;
            assign op_b     = b_eff;
            assign c_in     = cin_eff;
            assign v_in     = in_valid;
            assign sum_next = seg_sum;
         end else begin : src
            // Lower sum bits ride along; the new segment lands on top.
            assign op_a     = stg[gi-1].ops.a_reg;
            assign op_b     = stg[gi-1].ops.b_reg;
            assign c_in     = stg[gi-1].carry_reg;
            assign v_in     = stg[gi-1].valid_reg;
            assign sum_next = {seg_sum, stg[gi-1].sum_reg};
         end

         always_comb begin
            carry_next = c_in;
            seg_sum    = '0;
            for (int bi = 0; bi < SEG; bi++) begin
               {carry_next, seg_sum[bi]} = full_add(op_a[bi], op_b[bi], carry_next);
            end
         end

         always_ff @(posedge clk) begin
            if (rst) begin
               valid_reg <= 1'b0;
               carry_reg <= 1'b0;
               sum_reg   <= '0;
            end else if (adv) begin
               valid_reg <= v_in;
               carry_reg <= carry_next;
               sum_reg   <= sum_next;
            end
         end

         if (gi < STAGES - 1) begin : ops
            logic [W_IN-SEG-1:0] a_reg;
            logic [W_IN-SEG-1:0] b_reg;

            always_ff @(posedge clk) begin
               if (rst) begin
                  a_reg <= '0;
                  b_reg <= '0;
               end else if (adv) begin
                  a_reg <= op_a[W_IN-1:SEG];
                  b_reg <= op_b[W_IN-1:SEG];
               end
            end
         end

         if (gi == STAGES - 1) begin : fin
            logic ovf_reg;

            // Carry into the MSB is recovered as a ^ b ^ sum of that bit.
            always_ff @(posedge clk) begin
               if (rst) begin
                  ovf_reg <= 1'b0;
               end else if (adv) begin
                  ovf_reg <= op_a[SEG-1] ^ op_b[SEG-1] ^ seg_sum[SEG-1] ^ carry_next;
               end
            end
         end
      end
   endgenerate

   assign out_valid = stg[STAGES-1].valid_reg;
   assign s         = stg[STAGES-1].sum_reg;
   assign cout      = stg[STAGES-1].carry_reg;
   assign ovf       = stg[STAGES-1].fin.ovf_reg;

   assign adv      = !out_valid | out_ready;
   assign in_ready = adv;
endmodule

// File: tb/tb_pipe_adder.sv
// Scoreboard bench for pipe_adder: WIDTH=8/STAGES=2 directed vectors plus an exhaustive WIDTH=2 instance.
// Subtract vectors run only when PIPE_ADDER_SUB_EN is defined.
module tb_pipe_adder;
   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst = 1'b1;
   logic       in_valid = 1'b0;
   logic       in_ready;
   logic [7:0] a = '0;
   logic [7:0] b = '0;
   logic       cin = 1'b0;
   logic       out_valid;
   logic       out_ready = 1'b1;
   logic [7:0] s;
   logic       cout;
   logic       ovf;
`ifdef PIPE_ADDER_SUB_EN
   logic       sub = 1'b0;
   logic       sub2 = 1'b0;
`endif

   logic       in_valid2 = 1'b0;
   logic       in_ready2;
   logic [1:0] a2 = '0;
   logic [1:0] b2 = '0;
   logic       cin2 = 1'b0;
   logic       out_valid2;
   logic       out_ready2 = 1'b1;
   logic [1:0] s2;
   logic       cout2;
   logic       ovf2;

   pipe_adder #(.WIDTH(8), .STAGES(2)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin),
`ifdef PIPE_ADDER_SUB_EN
      .sub(sub),
`endif
      .out_valid(out_valid), .out_ready(out_ready), .s(s), .cout(cout), .ovf(ovf)
   );

   pipe_adder #(.WIDTH(2), .STAGES(2)) dut2 (
      .clk(clk), .rst(rst), .in_valid(in_valid2), .in_ready(in_ready2),
      .a(a2), .b(b2), .cin(cin2),
`ifdef PIPE_ADDER_SUB_EN
      .sub(sub2),
`endif
      .out_valid(out_valid2), .out_ready(out_ready2), .s(s2), .cout(cout2), .ovf(ovf2)
   );

   int n_cmp = 0;
   int n_bad = 0;
   logic [9:0] q[$];
   logic [3:0] q2[$];

   task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
      n_cmp++;
      if (got !== want) begin
         n_bad++;
         $display("FAIL %-16s got=%h want=%h t=%0t", name, got, want, $time);
      end else begin
         $display("ok   %-16s got=%h t=%0t", name, got, $time);
      end
   endtask

   // Monitor for the 8-bit instance: pops on handshake, checks held outputs under backpressure.
   logic       hold_v = 1'b0;
   logic [9:0] hold_d = '0;
   always @(negedge clk) begin
      if (rst) begin
         hold_v <= 1'b0;
      end else begin
         if (hold_v) chk("hold_stable", 16'({out_valid, ovf, cout, s}), 16'({1'b1, hold_d}));
         hold_v <= out_valid && !out_ready;
         hold_d <= {ovf, cout, s};
         if (out_valid && out_ready) begin
            if (q.size() == 0) chk("unexpected_out", 16'({ovf, cout, s}), 16'hFFFF);
            else chk("result", 16'({ovf, cout, s}), 16'(q.pop_front()));
         end
      end
   end

   logic       hold2_v = 1'b0;
   logic [3:0] hold2_d = '0;
   always @(negedge clk) begin
      if (rst) begin
         hold2_v <= 1'b0;
      end else begin
         if (hold2_v) chk("hold2_stable", 16'({out_valid2, ovf2, cout2, s2}), 16'({1'b1, hold2_d}));
         hold2_v <= out_valid2 && !out_ready2;
         hold2_d <= {ovf2, cout2, s2};
         if (out_valid2 && out_ready2) begin
            if (q2.size() == 0) chk("unexpected_out2", 16'({ovf2, cout2, s2}), 16'hFFFF);
            else chk("result2", 16'({ovf2, cout2, s2}), 16'(q2.pop_front()));
         end
      end
   end

   logic rnd_en = 1'b0;
   initial begin
      forever begin
         @(posedge clk);
         #1;
         if (rnd_en) out_ready2 = 1'($urandom_range(0, 1));
      end
   end

   // Expected value packing: {ovf, cout, s}.
   task automatic send(input logic [7:0] ta, input logic [7:0] tb, input logic tc,
                       input logic ts, input logic [9:0] e);
      int  n = 0;
      logic acc = 1'b0;
      a = ta; b = tb; cin = tc; in_valid = 1'b1;
`ifdef PIPE_ADDER_SUB_EN
      sub = ts;
`else
      if (ts) $display("note: sub requested without subtract support");
`endif
      forever begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         if (acc) break;
         n++;
         if (n > 200) break;
      end
      if (acc) q.push_back(e);
      else chk("send_timeout", 16'(acc), 16'd1);
      #1 in_valid = 1'b0;
   endtask

   task automatic send2(input logic [1:0] ta, input logic [1:0] tb, input logic tc,
                        input logic [3:0] e);
      int  n = 0;
      logic acc = 1'b0;
      a2 = ta; b2 = tb; cin2 = tc; in_valid2 = 1'b1;
      forever begin
         @(negedge clk);
         acc = in_ready2;
         @(posedge clk);
         if (acc) break;
         n++;
         if (n > 200) break;
      end
      if (acc) q2.push_back(e);
      else chk("send2_timeout", 16'(acc), 16'd1);
      #1 in_valid2 = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while ((q.size() != 0 || out_valid) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_empty", 16'(q.size()), 16'd0);
   endtask

   task automatic drain2();
      int n = 0;
      while ((q2.size() != 0 || out_valid2) && n < 400) begin
         @(negedge clk);
         n++;
      end
      chk("drain2_empty", 16'(q2.size()), 16'd0);
   endtask

   initial begin
      // Reset state
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", 16'(out_valid), 16'd0);
      chk("rst_s", 16'(s), 16'd0);
      chk("rst_cout", 16'(cout), 16'd0);
      chk("rst_ovf", 16'(ovf), 16'd0);
      chk("rst_in_ready", 16'(in_ready), 16'd1);
      chk("rst2_out_valid", 16'(out_valid2), 16'd0);
      @(posedge clk);
      #1;

      // Segment-boundary carry and two-cycle latency
      send(8'h0F, 8'h01, 1'b0, 1'b0, {1'b0, 1'b0, 8'h10});
      @(negedge clk);
      chk("lat_cycle1", 16'(out_valid), 16'd0);
      @(negedge clk);
      chk("lat_cycle2", 16'(out_valid), 16'd1);
      @(posedge clk);
      #1;
      send(8'hFF, 8'h00, 1'b1, 1'b0, {1'b0, 1'b1, 8'h00});
      send(8'h7F, 8'h01, 1'b0, 1'b0, {1'b1, 1'b0, 8'h80});
      drain();

      // Backpressure after the first result of a 4-op stream
      @(posedge clk);
      #1 out_ready = 1'b1;
      fork
         begin
            send(8'h12, 8'h34, 1'b0, 1'b0, {1'b0, 1'b0, 8'h46});
            send(8'h80, 8'h80, 1'b0, 1'b0, {1'b1, 1'b1, 8'h00});
            send(8'h55, 8'hAA, 1'b1, 1'b0, {1'b0, 1'b1, 8'h00});
            send(8'h3C, 8'hC3, 1'b0, 1'b0, {1'b0, 1'b0, 8'hFF});
         end
         begin
            int n = 0;
            do begin
               @(negedge clk);
               n++;
            end while (!out_valid && n < 50);
            @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (4) @(negedge clk);
            chk("bp_in_ready", 16'(in_ready), 16'd0);
            chk("bp_out_valid", 16'(out_valid), 16'd1);
            @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();

      // Reset with two operations in flight
      @(posedge clk);
      #1 out_ready = 1'b0;
      send(8'h01, 8'h01, 1'b0, 1'b0, {1'b0, 1'b0, 8'h02});
      send(8'h02, 8'h02, 1'b0, 1'b0, {1'b0, 1'b0, 8'h04});
      rst = 1'b1;
      q.delete();
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("rst_mid_valid", 16'(out_valid), 16'd0);
      @(posedge clk);
      #1 out_ready = 1'b1;
      repeat (6) @(negedge clk);
      chk("rst_mid_quiet", 16'(out_valid), 16'd0);
      @(posedge clk);
      #1;

`ifdef PIPE_ADDER_SUB_EN
      send(8'h05, 8'h07, 1'b0, 1'b1, {1'b0, 1'b0, 8'hFE});
      send(8'h80, 8'h01, 1'b0, 1'b1, {1'b1, 1'b1, 8'h7F});
      send(8'h09, 8'h03, 1'b1, 1'b1, {1'b0, 1'b1, 8'h06});
      send(8'h09, 8'h03, 1'b1, 1'b0, {1'b0, 1'b0, 8'h0D});
      drain();
`endif

      // Exhaustive 2-bit instance under random backpressure
      rnd_en = 1'b1;
      for (int ia = 0; ia < 4; ia++) begin
         for (int ib = 0; ib < 4; ib++) begin
            for (int ic = 0; ic < 2; ic++) begin
               logic [1:0] ta;
               logic [1:0] tb;
               logic [2:0] tot;
               logic       sov;
               ta  = 2'(ia);
               tb  = 2'(ib);
               tot = 3'(ia) + 3'(ib) + 3'(ic);
               sov = (ta[1] == tb[1]) && (tot[1] != ta[1]);
               send2(ta, tb, 1'(ic), {sov, tot});
            end
         end
      end
      drain2();
      rnd_en = 1'b0;

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
